mem_access_unit: RTL

//  Downstream stage of the op/select access-control FSM.

---
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the access-control FSM (master) and
// the memory access unit (slave).
interface mem_access_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output valid, rw, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  valid, rw, addr, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: accepts one read/write request at a time from the
// access FSM, performs it on a small register memory and answers with a
// one-cycle done pulse (plus read data and an out-of-range flag).
module mem_access_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, RD_RESP, WR_RESP} state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              err_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              accept;
    logic              ready_next;
    logic              done_next;

    assign accept = bus.valid && (state_reg == IDLE);

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and handshake decode from the registered state only.
    always_comb begin
        state_next = state_reg;
        ready_next = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (bus.valid) state_next = bus.rw ? RD : WR_RESP;
            end
            RD:      state_next = RD_RESP;
            RD_RESP: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            WR_RESP: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the request address and its range check on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
            err_reg  <= 1'b0;
        end else if (accept) begin
            addr_reg <= bus.addr;
            err_reg  <= !({1'b0, bus.addr} < DEPTH_W);
        end
    end

    // One register per word; a write lands at the accept edge, and an
    // out-of-range address matches no word so the write is dropped.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    mem_reg[gi] <= '0;
                else if (accept && !bus.rw && (bus.addr == ADDR_W'(gi)))
                    mem_reg[gi] <= bus.wdata;
            end
        end
    endgenerate

    // Read mux; an address with no matching word reads as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_reg == ADDR_W'(i)) rd_word = mem_reg[i];
        end
    end

    // Read data is loaded in RD and held until the next read or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rdata_reg <= '0;
        else if (state_reg == RD)  rdata_reg <= rd_word;
    end

    assign bus.ready = ready_next;
    assign bus.done  = done_next;
    assign bus.err   = done_next & err_reg;
    assign bus.rdata = rdata_reg;
endmodule
